hazard_unit: RTL

Pipeline hazard resolver for the 5-stage ARM core. It consumes the hazard signals the pipeline controller exports (RegWriteM, MemtoRegE, BranchTakenE, PCSrcD/E/M/W) and returns the stall, flush and forwarding controls the controller and datapath act on, including FlushE, which clears the controller's Decode→Execute register. It keeps its own Execute/Memory/Writeback copies of the register addresses, aligned with the datapath pipeline registers. It also maintains saturating stall and flush event counters for performance debug.

---
 rtl/hazard_unit.sv | 71 +++++++
 1 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush/forward resolver for the 5-stage ARM pipeline with saturating event counters.
module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       WA3D,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             BranchTakenE,
    input  logic             PCSrcD,
    input  logic             PCSrcE,
    input  logic             PCSrcM,
    input  logic             PCSrcW,
    input  logic             cnt_clr,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    logic [3:0] ra1_e, ra2_e, wa3_e, wa3_m, wa3_w;
    logic       valid_e, valid_m, valid_w;
    logic       ldrstall, pcpend;

    always_comb begin
        ldrstall  = MemtoRegE & valid_e & (RA1D == wa3_e | RA2D == wa3_e);
        pcpend    = PCSrcD | PCSrcE | PCSrcM;
        StallF    = ldrstall | pcpend;
        StallD    = ldrstall;
        FlushD    = pcpend | PCSrcW | BranchTakenE;
        FlushE    = ldrstall | BranchTakenE;
        // R15 reads the PC, never a forwarded result
        ForwardAE = (valid_m & RegWriteM & ra1_e == wa3_m & ra1_e != 4'hf) ? 2'b10 :
                    (valid_w & RegWriteW & ra1_e == wa3_w & ra1_e != 4'hf) ? 2'b01 : 2'b00;
        ForwardBE = (valid_m & RegWriteM & ra2_e == wa3_m & ra2_e != 4'hf) ? 2'b10 :
                    (valid_w & RegWriteW & ra2_e == wa3_w & ra2_e != 4'hf) ? 2'b01 : 2'b00;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ra1_e     <= '0;
            ra2_e     <= '0;
            wa3_e     <= '0;
            wa3_m     <= '0;
            wa3_w     <= '0;
            valid_e   <= 1'b0;
            valid_m   <= 1'b0;
            valid_w   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            ra1_e     <= FlushE ? 4'd0 : RA1D;
            ra2_e     <= FlushE ? 4'd0 : RA2D;
            wa3_e     <= FlushE ? 4'd0 : WA3D;
            valid_e   <= !FlushE;
            wa3_m     <= wa3_e;
            valid_m   <= valid_e;
            wa3_w     <= wa3_m;
            valid_w   <= valid_m;
            stall_cnt <= cnt_clr ? '0 : (StallD && stall_cnt != '1) ? stall_cnt + 1'b1 : stall_cnt;
            flush_cnt <= cnt_clr ? '0 : (FlushE && flush_cnt != '1) ? flush_cnt + 1'b1 : flush_cnt;
        end
    end
endmodule
